// File: rtl/msg_pkg.sv
// Shared types and character constants for the UART message receiver.
package msg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] PRINT_LO   = 8'h20;
  localparam logic [7:0] PRINT_HI   = 8'h7E;

  function automatic logic is_print(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Bit-level 8N1 receiver: synchronizer, mid-bit sampling, stop check.
module uart_rx_core
  import msg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          vld_q, vld_d;
  logic          ferr_q, ferr_d;
  logic          s1_q, s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= rx_i;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    data_d  = data_q;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!s2_q) begin
          state_d = START;
          tmr_d   = '0;
        end
      end
      START: begin
        if (tmr_q == T_HALF) begin
          tmr_d   = '0;
          idx_d   = '0;
          state_d = s2_q ? IDLE : DATA;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      DATA: begin
        if (tmr_q == T_FULL) begin
          tmr_d  = '0;
          data_d = {s2_q, data_q[7:1]};
          idx_d  = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      STOP: begin
        if (tmr_q == T_FULL) begin
          tmr_d = '0;
          if (s2_q) begin
            vld_d   = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (s2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_o       = data_q;
  assign byte_valid_o = vld_q;
  assign frame_err_o  = ferr_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: rtl/uart_msg_rx.sv
// UART receiver feeding a 4-character edit buffer committed on CR.
module uart_msg_rx
  import msg_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        RX,
  output logic [31:0] MSG,
  output logic        MSG_VALID,
  output logic        FRAME_ERR,
  output logic        RX_BUSY
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam logic [31:0] SPACES = {4{CHAR_SPACE}};

  logic [7:0]  rx_byte;
  logic        rx_vld;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] msg_q, msg_d;
  logic        mvld_q, mvld_d;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk_i       (CLOCK_50),
    .rst_ni      (RESET_N),
    .rx_i        (RX),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_vld),
    .frame_err_o (FRAME_ERR),
    .busy_o      (RX_BUSY)
  );

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      shadow_q <= SPACES;
      msg_q    <= SPACES;
      mvld_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      msg_q    <= msg_d;
      mvld_q   <= mvld_d;
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    msg_d    = msg_q;
    mvld_d   = 1'b0;
    if (rx_vld) begin
      unique case (1'b1)
        is_print(rx_byte):
          shadow_d = {shadow_q[23:0], rx_byte};
        (rx_byte == CHAR_BS):
          shadow_d = {CHAR_SPACE, shadow_q[31:8]};
        (rx_byte == CHAR_CR): begin
          msg_d  = shadow_q;
          mvld_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign MSG       = msg_q;
  assign MSG_VALID = mvld_q;

endmodule

// File: tb/tb_uart_msg_rx.sv
// Bench for uart_msg_rx: vector table, corner sequences, random model check.
module tb_uart_msg_rx;

  localparam int CLK_HZ = 160_000;
  localparam int BAUD   = 10_000;
  localparam int CPB    = CLK_HZ / BAUD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rx = 1'b1;
  logic [31:0] msg;
  logic        mv, fe, busy;

  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  int fcnt = 0;

  uart_msg_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .RX       (rx),
    .MSG      (msg),
    .MSG_VALID(mv),
    .FRAME_ERR(fe),
    .RX_BUSY  (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (mv) vcnt++;
    if (fe) fcnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [63:0] seq;
    int          n;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  logic [7:0]  mq[$];
  logic [31:0] mmsg;
  int          mvalids;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(logic [7:0] b, int stop_low = 0);
    @(negedge clk);
    rx = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(CPB);
    end
    if (stop_low > 0) begin
      rx = 1'b0;
      cyc(stop_low * CPB);
    end
    rx = 1'b1;
    cyc(CPB);
  endtask

  task automatic do_reset();
    rx = 1'b1;
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic model_reset();
    mq = '{8'h20, 8'h20, 8'h20, 8'h20};
    mmsg = 32'h20202020;
    mvalids = 0;
  endtask

  task automatic model_byte(logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      void'(mq.pop_front());
      mq.push_back(b);
    end else if (b == 8'h08) begin
      void'(mq.pop_back());
      mq.push_front(8'h20);
    end else if (b == 8'h0D) begin
      mmsg = {mq[0], mq[1], mq[2], mq[3]};
      mvalids++;
    end
  endtask

  initial begin
    int v0, f0;
    logic [7:0] b;
    int r;

    vecs[0] = '{64'h436C61720D,   5, 32'h436C6172};
    vecs[1] = '{64'h41424344450D, 6, 32'h42434445};
    vecs[2] = '{64'h4142080D,     4, 32'h20202041};
    vecs[3] = '{64'h7801790D,     4, 32'h20207879};
    vecs[4] = '{64'h08080D,       3, 32'h20202020};
    vecs[5] = '{64'h7E7F200D,     4, 32'h20207E20};

    // async reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("reset msg", msg, 32'h20202020);
    check("reset msg_valid", {31'd0, mv}, 32'd0);
    check("reset frame_err", {31'd0, fe}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    for (int k = 0; k < 6; k++) begin
      do_reset();
      v0 = vcnt;
      f0 = fcnt;
      for (int i = 0; i < vecs[k].n; i++)
        send_byte(vecs[k].seq[8*(vecs[k].n-1-i) +: 8]);
      cyc(8);
      check($sformatf("vec%0d msg", k), msg, vecs[k].exp);
      check($sformatf("vec%0d valid pulses", k), vcnt - v0, 1);
      check($sformatf("vec%0d frame errs", k), fcnt - f0, 0);
    end

    do_reset();
    model_reset();
    v0 = vcnt;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) b = 8'($urandom_range(32, 126));
      else if (r == 6) b = 8'h08;
      else if (r == 8) b = ($urandom_range(0, 1) == 0) ?
                           8'($urandom_range(0, 7)) :
                           8'($urandom_range(127, 255));
      else b = 8'h0D;
      if (i == 39) b = 8'h0D;
      send_byte(b);
      model_byte(b);
      if (b == 8'h0D) begin
        cyc(6);
        check($sformatf("rand msg byte%0d", i), msg, mmsg);
      end
    end
    check("rand valid pulses", vcnt - v0, mvalids);

    // stop bit held low for two bit periods
    do_reset();
    send_byte("A");
    send_byte("B");
    send_byte(8'h0D);
    cyc(6);
    check("ferr pre msg", msg, 32'h20204142);
    v0 = vcnt;
    f0 = fcnt;
    send_byte("Q", 2);
    cyc(4);
    check("ferr pulses", fcnt - f0, 1);
    check("ferr msg held", msg, 32'h20204142);
    check("ferr no valid", vcnt - v0, 0);
    check("ferr busy idle", {31'd0, busy}, 32'd0);
    send_byte("Z");
    send_byte(8'h0D);
    cyc(6);
    check("ferr recover msg", msg, 32'h2041425A);

    // short low glitch must not start a frame
    v0 = vcnt;
    f0 = fcnt;
    @(negedge clk);
    rx = 1'b0;
    cyc(4);
    check("glitch busy", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    cyc(20);
    check("glitch back idle", {31'd0, busy}, 32'd0);
    cyc(CPB * 10);
    check("glitch no ferr", fcnt - f0, 0);
    check("glitch no valid", vcnt - v0, 0);
    check("glitch msg held", msg, 32'h2041425A);

    // reset in the middle of the data bits of "X"
    b = "X";
    @(negedge clk);
    rx = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      cyc(CPB);
    end
    check("mid-frame busy", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mid-frame reset busy", {31'd0, busy}, 32'd0);
    check("mid-frame reset msg", msg, 32'h20202020);
    cyc(3);
    rst_n = 1'b1;
    cyc(4);
    v0 = vcnt;
    send_byte("Y");
    send_byte(8'h0D);
    cyc(6);
    check("after reset msg", msg, 32'h20202059);
    check("after reset valid", vcnt - v0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
